// File: rtl/emesh_pkg.sv
// Shared emesh packet layout and receive-buffer occupancy encoding.
// The transmit-side packer uses the same offsets, so both ends change together.
package emesh_pkg;

    localparam int WRITE_LSB = 0;
    localparam int DMODE_LSB = 1;
    localparam int DMODE_W   = 2;
    localparam int CMODE_LSB = 3;
    localparam int CMODE_W   = 5;
    localparam int DST_LSB   = 8;
    localparam int DATA_LSB  = 40;
    localparam int SRC_LSB   = 72;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/emesh_pkt_fields.sv
// Combinational split of a raw emesh packet into its bundle fields.
module emesh_pkt_fields
    import emesh_pkg::*;
#(
    parameter int AW = 32,
    parameter int PW = 104
) (
    input  logic [PW-1:0]      packet,
    output logic               write,
    output logic [DMODE_W-1:0] datamode,
    output logic [CMODE_W-1:0] ctrlmode,
    output logic [AW-1:0]      dstaddr,
    output logic [AW-1:0]      data,
    output logic [AW-1:0]      srcaddr
);

    assign write    = packet[WRITE_LSB];
    assign datamode = packet[DMODE_LSB +: DMODE_W];
    assign ctrlmode = packet[CMODE_LSB +: CMODE_W];
    assign dstaddr  = packet[DST_LSB +: AW];
    assign data     = packet[DATA_LSB +: AW];
    assign srcaddr  = packet[SRC_LSB +: AW];

endmodule

// File: rtl/packet2emesh_buf.sv
// Two-entry registered receive buffer that decodes the head packet
// into an emesh signal bundle under access/wait handshakes.
module packet2emesh_buf
    import emesh_pkg::*;
#(
    parameter int AW = 32,
    parameter int PW = 104
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          access_in,
    input  logic [PW-1:0] packet_in,
    output logic          wait_out,
    output logic          access_out,
    output logic          write_out,
    output logic [1:0]    datamode_out,
    output logic [4:0]    ctrlmode_out,
    output logic [AW-1:0] dstaddr_out,
    output logic [AW-1:0] data_out,
    output logic [AW-1:0] srcaddr_out,
    input  logic          wait_in
);

    occ_t          state, state_nxt;
    logic [PW-1:0] head, head_nxt;
    logic [PW-1:0] tail, tail_nxt;
    logic          push, pop;

    assign wait_out   = reset || (state == TWO);
    assign access_out = (state != EMPTY);
    assign push       = access_in && !wait_out;
    assign pop        = access_out && !wait_in;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    head_nxt  = packet_in;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_nxt = packet_in;
                end else if (push) begin
                    state_nxt = TWO;
                    tail_nxt  = packet_in;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                // wait_out blocks any push while full
                if (pop) begin
                    state_nxt = ONE;
                    head_nxt  = tail;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

    emesh_pkt_fields #(
        .AW(AW),
        .PW(PW)
    ) u_fields (
        .packet   (head),
        .write    (write_out),
        .datamode (datamode_out),
        .ctrlmode (ctrlmode_out),
        .dstaddr  (dstaddr_out),
        .data     (data_out),
        .srcaddr  (srcaddr_out)
    );

endmodule

// File: tb/tb_packet2emesh_buf.sv
// Testbench for packet2emesh_buf: directed vector table plus random traffic against a queue model.
module tb_packet2emesh_buf;

    logic         clk;
    logic         reset;
    logic         access_in;
    logic [103:0] packet_in;
    logic         wait_out;
    logic         access_out;
    logic         write_out;
    logic [1:0]   datamode_out;
    logic [4:0]   ctrlmode_out;
    logic [31:0]  dstaddr_out;
    logic [31:0]  data_out;
    logic [31:0]  srcaddr_out;
    logic         wait_in;
    logic [103:0] bundle;

    packet2emesh_buf dut (
        .clk          (clk),
        .reset        (reset),
        .access_in    (access_in),
        .packet_in    (packet_in),
        .wait_out     (wait_out),
        .access_out   (access_out),
        .write_out    (write_out),
        .datamode_out (datamode_out),
        .ctrlmode_out (ctrlmode_out),
        .dstaddr_out  (dstaddr_out),
        .data_out     (data_out),
        .srcaddr_out  (srcaddr_out),
        .wait_in      (wait_in)
    );

    assign bundle = {srcaddr_out, data_out, dstaddr_out,
                     ctrlmode_out, datamode_out, write_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         acc;
        logic [103:0] pkt;
        logic         win;
        logic         e_acc;
        logic         e_wait;
        logic [103:0] e_pkt;
    } vec_t;

    vec_t         tv[23];
    logic [103:0] q[$];
    logic [103:0] last_head;
    int           n_chk;
    int           n_fail;
    int           n_in;
    int           n_out;

    function automatic logic [103:0] mkp(input logic [31:0] src,
                                         input logic [31:0] dat,
                                         input logic [31:0] dst,
                                         input logic [4:0]  cm,
                                         input logic [1:0]  dm,
                                         input logic        wr);
        return {src, dat, dst, cm, dm, wr};
    endfunction

    function automatic vec_t mkv(input logic r, input logic a,
                                 input logic [103:0] p, input logic w,
                                 input logic ea, input logic ew,
                                 input logic [103:0] ep);
        vec_t v;
        v.rst = r; v.acc = a; v.pkt = p; v.win = w;
        v.e_acc = ea; v.e_wait = ew; v.e_pkt = ep;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [103:0] act, input logic [103:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Model: a queue of at most two packets; transfers follow the handshake rules.
    task automatic advance(input logic r, input logic a,
                           input logic [103:0] p, input logic w);
        bit can_push;
        if (access_in && !wait_out) n_in++;
        if (access_out && !wait_in) n_out++;
        if (r) begin
            q.delete();
            last_head = '0;
        end else begin
            can_push = (q.size() < 2);
            if (q.size() > 0 && !w) void'(q.pop_front());
            if (a && can_push) q.push_back(p);
            if (q.size() > 0) last_head = q[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mcycle(input logic r, input logic a,
                          input logic [103:0] p, input logic w, input int idx);
        reset = r; access_in = a; packet_in = p; wait_in = w;
        #1;
        chk("access_out", idx, 104'(access_out), 104'(q.size() > 0));
        chk("wait_out", idx, 104'(wait_out), 104'(r || q.size() == 2));
        chk("bundle", idx, bundle, last_head);
        advance(r, a, p, w);
    endtask

    logic [103:0] p1, s1, s2, s3, s4, r1, r2, r3, ones, zero;
    logic [127:0] rnd;
    int           pops0;

    initial begin
        n_chk = 0; n_fail = 0; n_in = 0; n_out = 0;
        last_head = '0;
        reset = 1'b1; access_in = 1'b0; packet_in = '0; wait_in = 1'b0;

        p1   = mkp(32'hA5A5_0001, 32'hDEAD_BEEF, 32'h8000_0010, 5'h15, 2'b10, 1'b1);
        s1   = mkp(32'h5000_0001, 32'h1000_0001, 32'h2000_0001, 5'h01, 2'b01, 1'b0);
        s2   = mkp(32'h5000_0002, 32'h1000_0002, 32'h2000_0002, 5'h02, 2'b10, 1'b1);
        s3   = mkp(32'h5000_0003, 32'h1000_0003, 32'h2000_0003, 5'h03, 2'b11, 1'b0);
        s4   = mkp(32'h5000_0004, 32'h1000_0004, 32'h2000_0004, 5'h1F, 2'b00, 1'b1);
        r1   = mkp(32'hBAD0_0001, 32'hBAD1_0001, 32'hBAD2_0001, 5'h0A, 2'b01, 1'b1);
        r2   = mkp(32'hBAD0_0002, 32'hBAD1_0002, 32'hBAD2_0002, 5'h0B, 2'b10, 1'b0);
        r3   = mkp(32'hBAD0_0003, 32'hBAD1_0003, 32'hBAD2_0003, 5'h0C, 2'b11, 1'b1);
        ones = '1;
        zero = '0;

        //             rst   acc   pkt   win   e_acc e_wait e_pkt
        tv[0]  = mkv(1'b1, 1'b1, p1,   1'b0, 1'b0, 1'b1, zero);
        tv[1]  = mkv(1'b0, 1'b1, p1,   1'b0, 1'b0, 1'b0, zero);
        tv[2]  = mkv(1'b0, 1'b0, zero, 1'b0, 1'b1, 1'b0, p1);
        tv[3]  = mkv(1'b0, 1'b0, zero, 1'b0, 1'b0, 1'b0, p1);
        tv[4]  = mkv(1'b0, 1'b1, s1,   1'b1, 1'b0, 1'b0, p1);
        tv[5]  = mkv(1'b0, 1'b1, s2,   1'b1, 1'b1, 1'b0, s1);
        tv[6]  = mkv(1'b0, 1'b1, s3,   1'b1, 1'b1, 1'b1, s1);
        tv[7]  = mkv(1'b0, 1'b1, s3,   1'b1, 1'b1, 1'b1, s1);
        tv[8]  = mkv(1'b0, 1'b1, s3,   1'b0, 1'b1, 1'b1, s1);
        tv[9]  = mkv(1'b0, 1'b1, s3,   1'b0, 1'b1, 1'b0, s2);
        tv[10] = mkv(1'b0, 1'b1, s4,   1'b0, 1'b1, 1'b0, s3);
        tv[11] = mkv(1'b0, 1'b0, zero, 1'b0, 1'b1, 1'b0, s4);
        tv[12] = mkv(1'b0, 1'b0, zero, 1'b0, 1'b0, 1'b0, s4);
        tv[13] = mkv(1'b0, 1'b1, r1,   1'b1, 1'b0, 1'b0, s4);
        tv[14] = mkv(1'b0, 1'b1, r2,   1'b1, 1'b1, 1'b0, r1);
        tv[15] = mkv(1'b1, 1'b1, r3,   1'b1, 1'b1, 1'b1, r1);
        tv[16] = mkv(1'b1, 1'b0, zero, 1'b0, 1'b0, 1'b1, zero);
        tv[17] = mkv(1'b0, 1'b0, zero, 1'b0, 1'b0, 1'b0, zero);
        tv[18] = mkv(1'b0, 1'b0, zero, 1'b0, 1'b0, 1'b0, zero);
        tv[19] = mkv(1'b0, 1'b1, ones, 1'b0, 1'b0, 1'b0, zero);
        tv[20] = mkv(1'b0, 1'b1, zero, 1'b0, 1'b1, 1'b0, ones);
        tv[21] = mkv(1'b0, 1'b0, zero, 1'b0, 1'b1, 1'b0, zero);
        tv[22] = mkv(1'b0, 1'b0, zero, 1'b0, 1'b0, 1'b0, zero);

        @(posedge clk); #1;
        advance(1'b1, 1'b0, '0, 1'b0);

        for (int i = 0; i < 23; i++) begin
            reset = tv[i].rst; access_in = tv[i].acc;
            packet_in = tv[i].pkt; wait_in = tv[i].win;
            #1;
            chk("tv_access", i, 104'(access_out), 104'(tv[i].e_acc));
            chk("tv_wait", i, 104'(wait_out), 104'(tv[i].e_wait));
            chk("tv_bundle", i, bundle, tv[i].e_pkt);
            advance(tv[i].rst, tv[i].acc, tv[i].pkt, tv[i].win);
        end

        // Back-to-back stream of eight packets with no stall.
        mcycle(1'b1, 1'b0, '0, 1'b0, 100);
        pops0 = n_out;
        for (int i = 0; i < 8; i++)
            mcycle(1'b0, 1'b1, mkp(32'hC0DE_0000, i, 32'h4000_0000 + i, 5'(i), 2'(i), 1'b0), 1'b0, 101 + i);
        for (int i = 0; i < 3; i++)
            mcycle(1'b0, 1'b0, '0, 1'b0, 109 + i);
        chk("stream_pops", 0, 104'(n_out - pops0), 104'd8);

        // Random traffic; no reset inside so the transfer counts must balance.
        n_in = 0; n_out = 0;
        for (int i = 0; i < 10000; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            mcycle(1'b0, ($urandom_range(0, 3) != 0), rnd[103:0],
                   ($urandom_range(0, 2) == 0), 1000 + i);
        end
        chk("conserve", 0, 104'(n_in), 104'(n_out + q.size()));
        chk("occupancy", 0, 104'(q.size() <= 2), 104'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
